turn_sequencer: RTL and testbench



---
 rtl/turn_sequencer_pkg.sv | 30 +++
 rtl/turn_sequencer_timer.sv | 32 +++
 rtl/turn_sequencer.sv | 136 +++++++++++++
 tb/tb_turn_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/turn_sequencer_pkg.sv
// Shared game package: FSM state encoding, player-index width and the
// turn-advance helper. Also imported by check_win.
package turn_sequencer_pkg;

  localparam int PLAYER_W = 2;
  localparam int TIMER_W  = 8;
  localparam int STREAK_W = 3;

  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLIP,
    CHECK,
    PASS,
    DONE
  } state_t;

  // Next player, wrapping at num_players rather than at 2**PLAYER_W.
  function automatic logic [PLAYER_W-1:0] next_player(
    input logic [PLAYER_W-1:0] cur,
    input int                  num_players
  );
    if (cur == PLAYER_W'(num_players - 1))
      return '0;
    else
      return cur + PLAYER_W'(1);
  endfunction

endpackage

// File: rtl/turn_sequencer_timer.sv
// turn_timer: per-turn flip timer.
//   clk     sole clock
//   rst     asynchronous active-low reset
//   clear   zero the count (wins over enable)
//   enable  count up by one this cycle
//   tc      high while the count equals TERMINAL-1
module turn_timer
  import turn_sequencer_pkg::*;
#(
  parameter int TERMINAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + TIMER_W'(1);
  end

  assign tc = (count == TIMER_W'(TERMINAL - 1));

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: turn control for a card-matching game.
//   clk         sole clock
//   rst         asynchronous active-low reset
//   start       pulse: begin a game (honored in IDLE and DONE only)
//   flip_valid  pulse: current player flipped a card
//   flip_match  qualifies flip_valid: card matches the target tile
//   W           win flag from check_win for the current player
//   T           current player index
//   B           one-cycle advance pulse to check_win
//   flip_ready  high while a flip is accepted
//   game_over   high from win detection until the next start
//   winner      winning player, valid while game_over is high
//   streak      consecutive matches this turn, saturating at 7
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_FLIP | current player may flip; timer running
// CHECK     | B high; W sampled at the end of this cycle
// PASS      | turn moves to the next player
// DONE      | game won; outputs hold until start
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int NUM_PLAYERS  = 4,
  parameter int FLIP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flip_valid,
  input  logic                flip_match,
  input  logic                W,
  output logic [PLAYER_W-1:0] T,
  output logic                B,
  output logic                flip_ready,
  output logic                game_over,
  output logic [PLAYER_W-1:0] winner,
  output logic [STREAK_W-1:0] streak
);

  state_t              state_q, state_d;
  logic [PLAYER_W-1:0] t_q, t_d;
  logic [PLAYER_W-1:0] winner_q, winner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                over_q, over_d;
  logic                timer_tc;
  logic                in_wait;

  assign in_wait = (state_q == WAIT_FLIP);

  // The timer only runs in WAIT_FLIP and is zero on every entry to it;
  // any flip restarts it so a turn kept by matching gets a fresh budget.
  turn_timer #(
    .TERMINAL (FLIP_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait || flip_valid),
    .enable (in_wait),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      winner_q <= '0;
      streak_q <= '0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      winner_q <= winner_d;
      streak_q <= streak_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    winner_d = winner_q;
    streak_d = streak_q;
    over_d   = over_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          t_d      = '0;
          streak_d = '0;
          over_d   = 1'b0;
          state_d  = WAIT_FLIP;
        end
      end
      WAIT_FLIP: begin
        // A flip landing on the timeout cycle takes priority.
        if (flip_valid) begin
          if (flip_match) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX
                                                : streak_q + STREAK_W'(1);
            state_d  = CHECK;
          end else begin
            state_d  = PASS;
          end
        end else if (timer_tc) begin
          state_d = PASS;
        end
      end
      CHECK: begin
        if (W) begin
          winner_d = t_q;
          over_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = WAIT_FLIP;
        end
      end
      PASS: begin
        t_d      = next_player(t_q, NUM_PLAYERS);
        streak_d = '0;
        state_d  = WAIT_FLIP;
      end
      default: state_d = IDLE;
    endcase
  end

  // B is decoded from CHECK, which is always a single-cycle state,
  // so it can never be high two cycles running and drops with reset.
  assign B          = (state_q == CHECK);
  assign flip_ready = in_wait;
  assign T          = t_q;
  assign winner     = winner_q;
  assign streak     = streak_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       flip_valid = 1'b0;
  logic       flip_match = 1'b0;
  logic       W = 1'b0;
  logic [1:0] T, winner, T3, winner3;
  logic       B, flip_ready, game_over, B3, flip_ready3, game_over3;
  logic [2:0] streak, streak3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  turn_sequencer #(.NUM_PLAYERS(4), .FLIP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .flip_valid(flip_valid),
    .flip_match(flip_match), .W(W), .T(T), .B(B), .flip_ready(flip_ready),
    .game_over(game_over), .winner(winner), .streak(streak)
  );

  turn_sequencer #(.NUM_PLAYERS(3), .FLIP_TIMEOUT(16)) dut3 (
    .clk(clk), .rst(rst), .start(start), .flip_valid(flip_valid),
    .flip_match(flip_match), .W(W), .T(T3), .B(B3), .flip_ready(flip_ready3),
    .game_over(game_over3), .winner(winner3), .streak(streak3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One flip pulse, sampled at the next edge.
  task automatic flip(input logic m);
    flip_valid = 1'b1;
    flip_match = m;
    tick();
    flip_valid = 1'b0;
    flip_match = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_T", T, 0);
    chk("rst_B", B, 0);
    chk("rst_ready", flip_ready, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_streak", streak, 0);

    rst = 1'b1;
    tick(3);
    chk("idle_hold", flip_ready, 0);

    // Mismatch: no B, T advances two cycles after the flip.
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ready", flip_ready, 1);
    chk("start_T", T, 0);
    flip(1'b0);
    chk("miss_noB", B, 0);
    chk("miss_pass_ready", flip_ready, 0);
    chk("miss_T_hold", T, 0);
    tick();
    chk("miss_T1", T, 1);
    chk("miss3_T1", T3, 1);
    chk("miss_ready", flip_ready, 1);

    // Wrap: 3 players go 1,2,0,1 while 4 players go 1,2,3,0.
    flip(1'b0); tick();
    chk("miss3_T2", T3, 2);
    chk("miss_T2", T, 2);
    flip(1'b0); tick();
    chk("miss3_T0", T3, 0);
    chk("miss_T3", T, 3);
    flip(1'b0); tick();
    chk("miss3_T1b", T3, 1);
    chk("miss_T0", T, 0);

    // Match with W=0: single B, same player, streak counts and saturates.
    flip(1'b1);
    chk("match_B", B, 1);
    chk("match_streak", streak, 1);
    chk("match_ready", flip_ready, 0);
    tick();
    chk("match_B_drop", B, 0);
    chk("match_T", T, 0);
    chk("match_ready2", flip_ready, 1);
    for (int i = 0; i < 7; i++) begin
      flip(1'b1);
      chk("sat_B", B, 1);
      tick();
      chk("sat_B_drop", B, 0);
    end
    chk("sat_streak", streak, 7);
    chk("sat_T", T, 0);

    // Timeout with no flip.
    tick(15);
    chk("to_still_wait", flip_ready, 1);
    tick();
    chk("to_pass", flip_ready, 0);
    chk("to_T_hold", T, 0);
    tick();
    chk("to_T1", T, 1);
    chk("to_streak", streak, 0);

    // Flip on the timeout cycle is honored.
    tick(15);
    flip(1'b1);
    chk("to_flip_B", B, 1);
    chk("to_flip_streak", streak, 1);
    tick();
    chk("to_flip_T", T, 1);
    chk("to_flip_ready", flip_ready, 1);

    // start is ignored mid-game.
    flip(1'b0); tick();
    chk("T2", T, 2);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ign_T", T, 2);
    chk("start_ign_ready", flip_ready, 1);

    // Win by player 2.
    flip(1'b1);
    W = 1'b1; tick(); W = 1'b0;
    chk("win_over", game_over, 1);
    chk("win_winner", winner, 2);
    chk("win_T", T, 2);
    chk("win_ready", flip_ready, 0);
    flip(1'b1);
    chk("done_noB", B, 0);
    chk("done_over", game_over, 1);
    tick();
    chk("done_noB2", B, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_over", game_over, 0);
    chk("restart_T", T, 0);
    chk("restart_streak", streak, 0);
    chk("restart_ready", flip_ready, 1);

    // Reset during the B cycle.
    flip(1'b1);
    chk("pre_rst_B", B, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_B", B, 0);
    chk("mid_rst_T", T, 0);
    chk("mid_rst_streak", streak, 0);
    chk("mid_rst_ready", flip_ready, 0);
    chk("mid_rst_winner", winner, 0);
    chk("mid_rst_over", game_over, 0);
    tick();
    rst = 1'b1;
    tick(3);
    chk("post_rst_idle", flip_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("post_rst_start", flip_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
